// File: rtl/combo_writer.sv
// combo_writer: programs a new NDIGITS-digit combination into the lock.
// The user enters the code once, confirms it a second time, and only a matching
// confirmation commits the new value to the code output.
module combo_writer #(
   parameter int unsigned           NDIGITS      = 6,
   parameter logic [4*NDIGITS-1:0]  DEFAULT_CODE = 24'h483815
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              digit,
   input  logic                    enter_btn,
   input  logic                    start,
   input  logic                    abort,
   output logic [4*NDIGITS-1:0]    code,
   output logic [2:0]              state_out,
   output logic [2:0]              digit_idx,
   output logic                    bad_digit,
   output logic                    done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENTER   = 3'd1,
      CONFIRM = 3'd2,
      COMMIT  = 3'd3,
      ERROR   = 3'd4
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'(NDIGITS - 1);

   state_t               state_q;
   logic [2:0]           idx_q;
   logic [3:0]           digits_q [NDIGITS];
   logic [4*NDIGITS-1:0] code_q;
   logic [4*NDIGITS-1:0] code_d;
   logic                 bad_q;
   logic                 done_q;
   logic                 btn_q;

   logic                 press;
   logic                 digit_ok;
   logic                 digit_match;

   // Rising-edge press detect on the level button, plus digit qualification.
   always_comb begin
      press       = enter_btn & ~btn_q;
      digit_ok    = (digit <= 4'd9);
      digit_match = (digit == digits_q[idx_q]);
   end

   // Pack the entry buffer into the code word, first digit in the MS nibble.
   always_comb begin
      code_d = '0;
      for (int unsigned i = 0; i < NDIGITS; i++) begin
         code_d[4*(NDIGITS-1-i) +: 4] = digits_q[i];
      end
   end

   // Programming FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         code_q  <= DEFAULT_CODE;
         bad_q   <= 1'b0;
         done_q  <= 1'b0;
         // Held high so a button held across reset release is not a press.
         btn_q   <= 1'b1;
         for (int unsigned i = 0; i < NDIGITS; i++) begin
            digits_q[i] <= '0;
         end
      end else begin
         btn_q  <= enter_btn;
         bad_q  <= 1'b0;
         done_q <= 1'b0;
         if (abort && (state_q != COMMIT)) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int unsigned i = 0; i < NDIGITS; i++) begin
               digits_q[i] <= '0;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     state_q <= ENTER;
                     idx_q   <= '0;
                  end
               end
               ENTER: begin
                  if (press) begin
                     if (!digit_ok) begin
                        bad_q <= 1'b1;
                     end else begin
                        digits_q[idx_q] <= digit;
                        if (idx_q == LAST_IDX) begin
                           state_q <= CONFIRM;
                           idx_q   <= '0;
                        end else begin
                           idx_q <= idx_q + 3'd1;
                        end
                     end
                  end
               end
               CONFIRM: begin
                  if (press) begin
                     if (!digit_ok) begin
                        bad_q <= 1'b1;
                     end else if (digit_match) begin
                        if (idx_q == LAST_IDX) begin
                           state_q <= COMMIT;
                           idx_q   <= '0;
                        end else begin
                           idx_q <= idx_q + 3'd1;
                        end
                     end else begin
                        state_q <= ERROR;
                        idx_q   <= '0;
                     end
                  end
               end
               COMMIT: begin
                  code_q  <= code_d;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
                  idx_q   <= '0;
               end
               ERROR: begin
                  if (start) begin
                     state_q <= ENTER;
                     idx_q   <= '0;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  idx_q   <= '0;
               end
            endcase
         end
      end
   end

   assign code      = code_q;
   assign state_out = state_q;
   assign digit_idx = idx_q;
   assign bad_digit = bad_q;
   assign done      = done_q;

endmodule

// File: tb/tb_combo_writer.sv
// Directed bench for combo_writer: walks through reset, programming, bad digits,
// confirmation mismatch, abort handling and button-hold behaviour.
module tb_combo_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  digit;
   logic        enter_btn;
   logic        start;
   logic        abort;
   logic [23:0] code;
   logic [2:0]  state_out;
   logic [2:0]  digit_idx;
   logic        bad_digit;
   logic        done;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   combo_writer #(.NDIGITS(6), .DEFAULT_CODE(24'h483815)) dut (
      .clk       (clk),
      .rst       (rst),
      .digit     (digit),
      .enter_btn (enter_btn),
      .start     (start),
      .abort     (abort),
      .code      (code),
      .state_out (state_out),
      .digit_idx (digit_idx),
      .bad_digit (bad_digit),
      .done      (done)
   );

   always #5 clk = ~clk;

   // One active edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Press edge only; button is left high.
   task automatic press_only(input logic [3:0] d);
      digit     = d;
      enter_btn = 1'b1;
      tick();
   endtask

   task automatic release_btn();
      enter_btn = 1'b0;
      tick();
   endtask

   task automatic press(input logic [3:0] d);
      press_only(d);
      release_btn();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b0; digit = '0; enter_btn = 1'b1; start = 1'b0; abort = 1'b0;
      tick();
      tick();
      check("rst_state", 24'(state_out), 24'd0);
      check("rst_code", code, 24'h483815);
      check("rst_idx", 24'(digit_idx), 24'd0);
      check("rst_done", 24'(done), 24'd0);
      check("rst_bad", 24'(bad_digit), 24'd0);

      // Button held through reset release, then into ENTER: no press.
      rst = 1'b1;
      tick();
      check("held_state", 24'(state_out), 24'd0);
      pulse_start();
      check("held_enter", 24'(state_out), 24'd1);
      tick();
      tick();
      check("held_idx", 24'(digit_idx), 24'd0);
      release_btn();

      // Enter 1..6 then confirm 1..6.
      press(4'd1); press(4'd2); press(4'd3);
      check("ent_idx3", 24'(digit_idx), 24'd3);
      press(4'd4); press(4'd5);
      press_only(4'd6);
      check("ent_to_confirm", 24'(state_out), 24'd2);
      check("ent_idx_clr", 24'(digit_idx), 24'd0);
      release_btn();
      press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
      press_only(4'd6);
      check("commit_state", 24'(state_out), 24'd3);
      check("commit_done0", 24'(done), 24'd0);
      check("commit_code_old", code, 24'h483815);
      release_btn();
      check("post_commit_state", 24'(state_out), 24'd0);
      check("done_pulse", 24'(done), 24'd1);
      check("new_code", code, 24'h123456);
      tick();
      check("done_one_cycle", 24'(done), 24'd0);

      // Bad digit in ENTER at index 2, and in CONFIRM.
      pulse_start();
      press(4'd1); press(4'd2);
      press_only(4'hB);
      check("bad_enter_pulse", 24'(bad_digit), 24'd1);
      check("bad_enter_idx", 24'(digit_idx), 24'd2);
      check("bad_enter_state", 24'(state_out), 24'd1);
      release_btn();
      check("bad_enter_clr", 24'(bad_digit), 24'd0);
      check("bad_enter_idx2", 24'(digit_idx), 24'd2);
      press(4'd3); press(4'd4); press(4'd5); press(4'd6);
      check("bad_then_confirm", 24'(state_out), 24'd2);
      press(4'd1);
      press_only(4'hF);
      check("bad_conf_pulse", 24'(bad_digit), 24'd1);
      check("bad_conf_idx", 24'(digit_idx), 24'd1);
      check("bad_conf_state", 24'(state_out), 24'd2);
      release_btn();

      // Mismatch: confirm 1,2,9 against 1,2,3.
      press(4'd2);
      press_only(4'd9);
      check("mis_state", 24'(state_out), 24'd4);
      check("mis_idx", 24'(digit_idx), 24'd0);
      check("mis_code", code, 24'h123456);
      release_btn();
      press(4'd1);
      check("err_ignores_press", 24'(state_out), 24'd4);
      check("err_idx", 24'(digit_idx), 24'd0);
      pulse_start();
      check("err_restart", 24'(state_out), 24'd1);
      check("err_restart_idx", 24'(digit_idx), 24'd0);

      // Abort together with a press in CONFIRM at index 3.
      press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(4'd6);
      press(4'd1); press(4'd2); press(4'd3);
      check("pre_abort_idx", 24'(digit_idx), 24'd3);
      abort = 1'b1;
      press_only(4'd4);
      abort = 1'b0;
      check("abort_state", 24'(state_out), 24'd0);
      check("abort_idx", 24'(digit_idx), 24'd0);
      check("abort_code", code, 24'h123456);
      release_btn();

      // Held button in ENTER for 10 cycles yields one press.
      pulse_start();
      digit = 4'd5;
      enter_btn = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("hold_idx", 24'(digit_idx), 24'd1);
      release_btn();
      check("hold_idx_rel", 24'(digit_idx), 24'd1);

      // Abort and start during COMMIT are ignored.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      pulse_start();
      press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd5); press(4'd4);
      press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd5);
      press_only(4'd4);
      check("commit2_state", 24'(state_out), 24'd3);
      abort = 1'b1;
      start = 1'b1;
      release_btn();
      abort = 1'b0;
      start = 1'b0;
      check("commit_abort_state", 24'(state_out), 24'd0);
      check("commit_abort_done", 24'(done), 24'd1);
      check("commit_abort_code", code, 24'h987654);

      // Reset mid-ENTER discards the entry and restores the default code.
      pulse_start();
      press(4'd1); press(4'd2);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("midrst_state", 24'(state_out), 24'd0);
      check("midrst_idx", 24'(digit_idx), 24'd0);
      check("midrst_code", code, 24'h483815);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/combo_writer.md
COMBO_WRITER -- requirements
Module: combo_writer

Interface
REQ-001 The block SHALL have parameter NDIGITS, default 6, setting the number of digits in a combination.
REQ-002 The block SHALL have parameter DEFAULT_CODE, default 24'h483815 (width 4*NDIGITS), as the combination loaded at reset, first digit in the MS nibble.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, with reset synchronous and active-low.
REQ-005 The block SHALL have port digit, input, 4, the BCD digit from the switches.
REQ-006 The block SHALL have port enter_btn, input, 1, the active-high, level, already-synchronized entry button.
REQ-007 The block SHALL have port start, input, 1, a pulse that begins programming.
REQ-008 The block SHALL have port abort, input, 1, a pulse that cancels programming.
REQ-009 The block SHALL have port code, output, 4*NDIGITS, the committed combination for the lock.
REQ-010 The block SHALL have port state_out, output, 3, the FSM state for display.
REQ-011 The block SHALL have port digit_idx, output, 3, the index of the next digit expected.
REQ-012 The block SHALL have port bad_digit, output, 1, a one-cycle pulse on a rejected press.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse when a new code commits.

Function
REQ-014 A press SHALL be the cycle where enter_btn=1 and its previous registered sample=0; holding the button SHALL yield one press only.
REQ-015 The FSM SHALL have states IDLE=0, ENTER=1, CONFIRM=2, COMMIT=3, ERROR=4, as encoded on state_out.
REQ-016 In IDLE or ERROR, start=1 SHALL go to ENTER with digit_idx=0; in ENTER, CONFIRM and COMMIT, start SHALL be ignored.
REQ-017 In ENTER, a press with digit<=9 SHALL store digit into buf[digit_idx] and increment digit_idx.
REQ-018 In ENTER, the press at digit_idx=NDIGITS-1 SHALL store the digit, go to CONFIRM and clear digit_idx.
REQ-019 In ENTER or CONFIRM, a press with digit>9 SHALL assert bad_digit for the next cycle only and SHALL change no state or index.
REQ-020 In CONFIRM, a press with digit<=9 equal to buf[digit_idx] SHALL increment digit_idx; at digit_idx=NDIGITS-1 it SHALL go to COMMIT.
REQ-021 In CONFIRM, a press with digit<=9 not equal to buf[digit_idx] SHALL go to ERROR with digit_idx=0.
REQ-022 COMMIT SHALL last exactly one cycle, during which code<=buf packed with first digit MS, done=1 for that cycle, and next state IDLE.
REQ-023 code SHALL change only in COMMIT; it SHALL stay stable through ENTER, CONFIRM, ERROR and abort.
REQ-024 ERROR SHALL hold until start or abort; presses in ERROR SHALL be ignored.
REQ-025 abort=1 in any state except COMMIT SHALL go to IDLE and clear digit_idx and buf, with priority over start and over a press in the same cycle.
REQ-026 abort during COMMIT SHALL be ignored, so the commit completes.
REQ-027 In IDLE, presses SHALL be ignored.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 When rst=0 at a clock edge, the block SHALL set state IDLE, digit_idx=0, buf=0, code=DEFAULT_CODE, bad_digit=0 and done=0.
REQ-030 When rst=0 at a clock edge, the enter_btn previous-sample register SHALL be set to 1, so a button held across reset release gives no press.
REQ-031 Reset asserted mid-ENTER or mid-CONFIRM SHALL discard the partial entry and restore DEFAULT_CODE.

Verification
REQ-032 Reset, then hold enter_btn=1 through release -> state_out=0, code=24'h483815, no press counted.
REQ-033 start, then enter 1,2,3,4,5,6, then confirm 1,2,3,4,5,6 -> state_out sequence 1,2,3,0, done one cycle, code=24'h123456.
REQ-034 In ENTER at digit_idx=2, press digit=4'hB -> bad_digit one cycle, digit_idx stays 2, state_out=1.
REQ-035 Confirm 1,2,9 against buf 1,2,3,... -> state_out=4 and code unchanged; then start -> state_out=1 and digit_idx=0.
REQ-036 In CONFIRM at digit_idx=3, abort and press in the same cycle -> state_out=0, digit_idx=0, code unchanged.
REQ-037 Hold enter_btn high for 10 cycles in ENTER -> digit_idx increments by exactly 1.
